// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Purpose  : I2C target (responder) for the EEPROM bus.
//            - Oversamples SCL/SDA on the system clock.
//            - Detects START and STOP conditions.
//            - Matches a 7-bit address and ACKs it.
//            - Moves bytes between the bus and a per-byte user interface.
//            SDA is open-drain: the block only ever pulls it low.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  localparam int             CW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_RX        = 3'd3;
  localparam logic [2:0] ST_RX_ACK    = 3'd4;
  localparam logic [2:0] ST_TX        = 3'd5;
  localparam logic [2:0] ST_TX_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  // Line index 0 is SCL, index 1 is SDA.
  logic [1:0]    sync1_q, sync2_q, filt_q, prev_q;
  logic [CW-1:0] fcnt_q [2];

  logic [2:0] state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       mack_q, mack_d;
  logic       tx_req_c;

  logic scl_f, sda_f;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;
  logic addr_match;

  // Synchronize both lines, then accept a new level only after it has been
  // seen FILT_LEN consecutive clocks. Idle bus level is high, so reset high
  // to avoid fake edges leaving reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      prev_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      sync1_q <= {sda_in, scl_in};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CNT_MAX) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  = filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] & prev_q[0];
  assign sda_rise  = filt_q[1] & ~prev_q[1];
  assign sda_fall  = ~filt_q[1] & prev_q[1];
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  // General call (address 0) is never claimed.
  assign addr_match = (shift_q[7:1] == DEV_ADDR) && (shift_q[7:1] != 7'h00);

  // Protocol state machine: next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    mack_d     = mack_q;
    tx_req_c   = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      bitcnt_d = 4'd0;
    end else if (start_det) begin
      // busy is deliberately kept across a repeated START.
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
      bitcnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_f};
            if (bitcnt_q != 4'd8) bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = 4'd0;
            if (addr_match) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              state_d  = ST_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              tx_req_c = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = ST_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX;
            end
          end
        end

        ST_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_f};
            if (bitcnt_q != 4'd8) bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d   = 4'd0;
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_RX_ACK;
          end
        end

        ST_RX_ACK: begin
          // rx_ready is taken in the rx_valid cycle; SCL is still low then.
          if (rx_valid_q) begin
            sda_oe_d = rx_ready;
            ack_d    = rx_ready;
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ack_q ? ST_RX : ST_WAIT_STOP;
          end
        end

        ST_TX: begin
          if (scl_rise) begin
            if (bitcnt_q != 4'd8) bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              bitcnt_d = 4'd0;
              sda_oe_d = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda_f;
          end else if (scl_fall) begin
            if (mack_q) begin
              tx_req_c = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = ST_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WAIT_STOP;
            end
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 4'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      mack_q     <= mack_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_c;
  assign busy     = busy_q;

endmodule
`default_nettype wire
